// File: rtl/conditional_unit_pkg.sv
// Shared types and constants for the execute-stage condition/flag unit.
package conditional_unit_pkg;

  localparam int FLAGS_W = 4;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_AL = 4'b0000,
    COND_EQ = 4'b0001,
    COND_NE = 4'b0010,
    COND_NV = 4'b0011,
    COND_GE = 4'b0100,
    COND_LT = 4'b0101,
    COND_GT = 4'b0110,
    COND_LE = 4'b0111,
    COND_CS = 4'b1000,
    COND_CC = 4'b1001,
    COND_MI = 4'b1010,
    COND_PL = 4'b1011,
    COND_VS = 4'b1100,
    COND_VC = 4'b1101,
    COND_HI = 4'b1110,
    COND_LS = 4'b1111
  } cond_t;

endpackage

// File: rtl/conditional_unit_cond_check.sv
// Condition evaluation: decodes the 4-bit condition field against the
// current NZCV flags. Purely combinational, every encoding yields 0 or 1.
module cond_check
  import conditional_unit_pkg::*;
(
  input  logic [3:0]         CondE,
  input  logic [FLAGS_W-1:0] Flags,
  output logic               CondEx
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_cond_ex;

  assign w_n = Flags[FLAG_N];
  assign w_z = Flags[FLAG_Z];
  assign w_c = Flags[FLAG_C];
  assign w_v = Flags[FLAG_V];

  // Decode the condition field into a single pass/fail bit
  always_comb begin
    w_cond_ex = 1'b0;
    case (cond_t'(CondE))
      COND_AL: w_cond_ex = 1'b1;
      COND_EQ: w_cond_ex = w_z;
      COND_NE: w_cond_ex = ~w_z;
      COND_NV: w_cond_ex = 1'b0;
      COND_GE: w_cond_ex = (w_n == w_v);
      COND_LT: w_cond_ex = (w_n != w_v);
      COND_GT: w_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: w_cond_ex = w_z | (w_n != w_v);
      COND_CS: w_cond_ex = w_c;
      COND_CC: w_cond_ex = ~w_c;
      COND_MI: w_cond_ex = w_n;
      COND_PL: w_cond_ex = ~w_n;
      COND_VS: w_cond_ex = w_v;
      COND_VC: w_cond_ex = ~w_v;
      COND_HI: w_cond_ex = w_c & ~w_z;
      COND_LS: w_cond_ex = ~w_c | w_z;
      default: w_cond_ex = 1'b0;
    endcase
  end

  assign CondEx = w_cond_ex;

endmodule

// File: rtl/conditional_unit.sv
// Execute-stage condition check and flag update. Combinational outputs
// (CondEx, FlagsNext, BranchTaken) are independent of reset; FlagsQ is a
// registered copy of FlagsNext that can be looped back as Flags.
module conditional_unit
  import conditional_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         CondE,
  input  logic [FLAGS_W-1:0] Flags,
  input  logic [FLAGS_W-1:0] ALUFlags,
  input  logic [1:0]         FlagsWrite,
  input  logic               BranchD,
  output logic               CondEx,
  output logic [FLAGS_W-1:0] FlagsNext,
  output logic               BranchTaken,
  output logic [FLAGS_W-1:0] FlagsQ
);

  logic               w_cond_ex;
  logic               w_write_nz;
  logic               w_write_cv;
  logic [FLAGS_W-1:0] w_flags_next;
  logic [FLAGS_W-1:0] r_flags_q;

  cond_check u_cond_check (
    .CondE  (CondE),
    .Flags  (Flags),
    .CondEx (w_cond_ex)
  );

  // A failed condition suppresses both write groups, so flags pass through
  assign w_write_nz = FlagsWrite[1] & w_cond_ex;
  assign w_write_cv = FlagsWrite[0] & w_cond_ex;

  assign w_flags_next[FLAG_N:FLAG_Z] = w_write_nz ? ALUFlags[FLAG_N:FLAG_Z]
                                                  : Flags[FLAG_N:FLAG_Z];
  assign w_flags_next[FLAG_C:FLAG_V] = w_write_cv ? ALUFlags[FLAG_C:FLAG_V]
                                                  : Flags[FLAG_C:FLAG_V];

  // Registered flags; reset wins over any write in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags_q <= 4'b0000;
    end else begin
      r_flags_q <= w_flags_next;
    end
  end

  assign CondEx      = w_cond_ex;
  assign FlagsNext   = w_flags_next;
  assign BranchTaken = BranchD & w_cond_ex;
  assign FlagsQ      = r_flags_q;

endmodule

// File: tb/tb_conditional_unit.sv
// Scoreboard bench for conditional_unit: stimulus pushes expected results,
// a negedge monitor pops and compares against the DUT outputs.
module tb_conditional_unit;

  logic       clk;
  logic       reset;
  logic [3:0] CondE;
  logic [3:0] Flags;
  logic [3:0] ALUFlags;
  logic [1:0] FlagsWrite;
  logic       BranchD;
  logic       CondEx;
  logic [3:0] FlagsNext;
  logic       BranchTaken;
  logic [3:0] FlagsQ;

  conditional_unit dut (
    .clk         (clk),
    .reset       (reset),
    .CondE       (CondE),
    .Flags       (Flags),
    .ALUFlags    (ALUFlags),
    .FlagsWrite  (FlagsWrite),
    .BranchD     (BranchD),
    .CondEx      (CondEx),
    .FlagsNext   (FlagsNext),
    .BranchTaken (BranchTaken),
    .FlagsQ      (FlagsQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         chk_cx;
    logic       cx;
    bit         chk_fn;
    logic [3:0] fn;
    bit         chk_bt;
    logic       bt;
    bit         chk_q;
    logic [3:0] q;
  } exp_t;

  exp_t exp_q[$];
  bit   pending;
  int   n_checks;
  int   n_fails;

  // Monitor: outputs are sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (pending) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL scoreboard_empty: sample pending but no expected entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk_cx) begin
          n_checks++;
          if (CondEx !== e.cx) begin
            n_fails++;
            $display("FAIL %s CondEx: got %b expected %b", e.name, CondEx, e.cx);
          end
        end
        if (e.chk_fn) begin
          n_checks++;
          if (FlagsNext !== e.fn) begin
            n_fails++;
            $display("FAIL %s FlagsNext: got %b expected %b", e.name, FlagsNext, e.fn);
          end
        end
        if (e.chk_bt) begin
          n_checks++;
          if (BranchTaken !== e.bt) begin
            n_fails++;
            $display("FAIL %s BranchTaken: got %b expected %b", e.name, BranchTaken, e.bt);
          end
        end
        if (e.chk_q) begin
          n_checks++;
          if (FlagsQ !== e.q) begin
            n_fails++;
            $display("FAIL %s FlagsQ: got %b expected %b", e.name, FlagsQ, e.q);
          end
        end
      end
      pending = 1'b0;
    end
  end

  // Queue one expectation; the monitor consumes it before the next rising edge
  task automatic expect_item(input exp_t e);
    exp_q.push_back(e);
    pending = 1'b1;
    @(posedge clk);
    if (pending) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s timeout: monitor did not sample", e.name);
      pending = 1'b0;
      void'(exp_q.pop_back());
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] f,
                       input logic [3:0] a, input logic [1:0] fw, input logic b);
    CondE      = c;
    Flags      = f;
    ALUFlags   = a;
    FlagsWrite = fw;
    BranchD    = b;
  endtask

  function automatic exp_t mk(input string nm,
                              input bit ccx, input logic vcx,
                              input bit cfn, input logic [3:0] vfn,
                              input bit cbt, input logic vbt,
                              input bit cq,  input logic [3:0] vq);
    exp_t e;
    e.name = nm;
    e.chk_cx = ccx; e.cx = vcx;
    e.chk_fn = cfn; e.fn = vfn;
    e.chk_bt = cbt; e.bt = vbt;
    e.chk_q  = cq;  e.q  = vq;
    return e;
  endfunction

  // Reference decode written directly from the condition table
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if      (c == 4'd0)  return 1'b1;
    else if (c == 4'd1)  return z;
    else if (c == 4'd2)  return !z;
    else if (c == 4'd3)  return 1'b0;
    else if (c == 4'd4)  return n ~^ v;
    else if (c == 4'd5)  return n ^ v;
    else if (c == 4'd6)  return !z && (n ~^ v);
    else if (c == 4'd7)  return z || (n ^ v);
    else if (c == 4'd8)  return cy;
    else if (c == 4'd9)  return !cy;
    else if (c == 4'd10) return n;
    else if (c == 4'd11) return !n;
    else if (c == 4'd12) return v;
    else if (c == 4'd13) return !v;
    else if (c == 4'd14) return cy && !z;
    else                 return !cy || z;
  endfunction

  logic [3:0] sweep_c [5];
  logic       sweep_x [5];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    pending  = 1'b0;
    reset    = 1'b1;
    drive(4'b0000, 4'b0000, 4'b1001, 2'b11, 1'b0);

    // Reset held over two edges; combinational outputs still live
    repeat (2) @(posedge clk);
    #1;
    expect_item(mk("reset_hold", 1'b1, 1'b1, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b1, 4'b0000));

    // Release reset: the first edge loads FlagsNext
    reset = 1'b0;
    @(posedge clk);
    #1;
    expect_item(mk("q_load", 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1001));

    // Re-assert reset: overrides the write that cycle
    reset = 1'b1;
    @(posedge clk);
    #1;
    expect_item(mk("q_reset", 1'b0, 1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 4'b0000));
    reset = 1'b0;

    // Failed condition must not modify registered flags
    drive(4'b0011, 4'b0110, 4'b1001, 2'b11, 1'b1);
    @(posedge clk);
    #1;
    expect_item(mk("q_nv_hold", 1'b1, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b1, 4'b0110));

    // Sweep with Flags=1010 (N=1,Z=0,C=1,V=0)
    sweep_c[0] = 4'b0000; sweep_x[0] = 1'b1;
    sweep_c[1] = 4'b0001; sweep_x[1] = 1'b0;
    sweep_c[2] = 4'b0010; sweep_x[2] = 1'b1;
    sweep_c[3] = 4'b0100; sweep_x[3] = 1'b0;
    sweep_c[4] = 4'b0101; sweep_x[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(sweep_c[i], 4'b1010, 4'b1010, 2'b11, 1'b1);
      expect_item(mk($sformatf("sweep_%0d", i), 1'b1, sweep_x[i], 1'b1, 4'b1010,
                     1'b1, sweep_x[i], 1'b0, 4'b0000));
    end

    // Conditional flag write gated by CondEx
    drive(4'b0001, 4'b0100, 4'b1011, 2'b11, 1'b0);
    expect_item(mk("eq_write", 1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 4'b0000));
    drive(4'b0010, 4'b0100, 4'b1011, 2'b11, 1'b0);
    expect_item(mk("ne_block", 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000));

    // Per-group write enables
    drive(4'b0000, 4'b0000, 4'b1111, 2'b10, 1'b0);
    expect_item(mk("write_nz", 1'b1, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0, 4'b0000));
    drive(4'b0000, 4'b0000, 4'b1111, 2'b01, 1'b0);
    expect_item(mk("write_cv", 1'b1, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 4'b0000));
    drive(4'b0000, 4'b0101, 4'b1010, 2'b00, 1'b0);
    expect_item(mk("write_none", 1'b1, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0000));

    // Branch resolution with Flags=0010 (C=1, Z=0)
    drive(4'b1110, 4'b0010, 4'b0000, 2'b00, 1'b1);
    expect_item(mk("br_hi", 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000));
    drive(4'b1111, 4'b0010, 4'b0000, 2'b00, 1'b1);
    expect_item(mk("br_ls", 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000));
    drive(4'b1110, 4'b0010, 4'b0000, 2'b00, 1'b0);
    expect_item(mk("br_nobranch", 1'b1, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000));

    // Combinational outputs ignore reset
    reset = 1'b1;
    drive(4'b0001, 4'b0100, 4'b1011, 2'b11, 1'b1);
    expect_item(mk("comb_in_reset", 1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 4'b0000));
    reset = 1'b0;

    // Exhaustive condition decode
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        drive(4'(c), 4'(f), 4'b0000, 2'b00, 1'b0);
        expect_item(mk($sformatf("decode_c%0d_f%0d", c, f),
                       1'b1, ref_cond(4'(c), 4'(f)), 1'b0, 4'b0000,
                       1'b0, 1'b0, 1'b0, 4'b0000));
      end
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
